// File: rtl/md_unit_pkg.sv
// Shared op-codes, FSM state encoding and default latencies for the
// multiply/divide unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_NONE7 = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    function automatic logic is_md_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_core.sv
// Purely combinational arithmetic for MULT/MULTU/DIV/DIVU; produces the
// HI/LO pair and a divide-by-zero flag that suppresses the commit.
module md_core
    import md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;

    always_comb begin
        sa     = {{32{a[31]}}, a};
        sb     = {{32{b[31]}}, b};
        prod_s = sa * sb;
        prod_u = {32'd0, a} * {32'd0, b};
        // A zero divisor is replaced so the dividers never see it; div0 discards the result.
        b_safe = (b == 32'd0) ? 32'd1 : b;
        // The most-negative / -1 quotient does not fit; pin it to the wrapped value.
        if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            quo_s = 32'sh8000_0000;
            rem_s = 32'sd0;
        end else begin
            quo_s = $signed(a) / $signed(b_safe);
            rem_s = $signed(a) % $signed(b_safe);
        end
        quo_u = a / b_safe;
        rem_u = a % b_safe;
    end

    always_comb begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
        case (op)
            MD_MULT:  begin hi = prod_s[63:32];   lo = prod_s[31:0];    end
            MD_MULTU: begin hi = prod_u[63:32];   lo = prod_u[31:0];    end
            MD_DIV:   begin hi = rem_s;           lo = quo_s;           div0 = (b == 32'd0); end
            MD_DIVU:  begin hi = rem_u;           lo = quo_u;           div0 = (b == 32'd0); end
            default:  begin hi = 32'd0;           lo = 32'd0;           end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, holds a pending result while
// the busy counter runs down, and commits it when the counter reaches zero.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        E_md_signal,
    input  logic [2:0]  E_md_control,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic [31:0] E_res_hi,
    output logic [31:0] E_res_lo,
    output logic [3:0]  busy,
    output md_state_e   state
);

    localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

    md_state_e   state_q, state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_div0;
    logic [31:0] core_hi, core_lo;
    logic        core_div0;
    logic        accept_md, write_hi, write_lo, commit, is_mult;

    md_core u_core (
        .op   (E_md_control),
        .a    (E_A),
        .b    (E_B),
        .hi   (core_hi),
        .lo   (core_lo),
        .div0 (core_div0)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            if (accept_md) begin
                pend_hi   <= core_hi;
                pend_lo   <= core_lo;
                pend_div0 <= core_div0;
            end
            if (commit) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end else begin
                if (write_hi) hi_q <= E_A;
                if (write_lo) lo_q <= E_A;
            end
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_md) begin
                    state_n = ST_RUN;
                    cnt_n   = is_mult ? MULT_LAT : DIV_LAT;
                end
            end
            ST_RUN: begin
                cnt_n = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Starts are only honoured in IDLE; anything arriving during RUN is dropped.
    always_comb begin
        is_mult   = (E_md_control == MD_MULT) || (E_md_control == MD_MULTU);
        accept_md = (state_q == ST_IDLE) && E_md_signal && is_md_op(E_md_control);
        write_hi  = (state_q == ST_IDLE) && E_md_signal && (E_md_control == MD_MTHI);
        write_lo  = (state_q == ST_IDLE) && E_md_signal && (E_md_control == MD_MTLO);
        commit    = (state_q == ST_RUN) && (cnt_q == 4'd1) && !pend_div0;
        E_res_hi  = hi_q;
        E_res_lo  = lo_q;
        busy      = cnt_q;
        state     = state_q;
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit against an arithmetic reference
// model; commits are checked by a monitor popping an expected-result queue.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        md_signal;
  logic [2:0]  md_control;
  logic [31:0] e_a, e_b;
  logic [31:0] res_hi, res_lo;
  logic [3:0]  busy;
  md_state_e   st;

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];

  int          m_cnt;
  logic [31:0] m_hi, m_lo, m_ph, m_pl;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk          (clk),
    .Reset        (rst_n),
    .E_md_signal  (md_signal),
    .E_md_control (md_control),
    .E_A          (e_a),
    .E_B          (e_b),
    .E_res_hi     (res_hi),
    .E_res_lo     (res_lo),
    .busy         (busy),
    .state        (st)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference arithmetic: returns {hi, lo} as the architecture should see it after commit
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint q, r;
    longint unsigned uq, ur;
    logic [63:0] res;
    res = {cur_hi, cur_lo};
    case (op)
      3'd1: res = sa * sb;
      3'd2: res = ua * ub;
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd4: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        res = {ur[31:0], uq[31:0]};
      end
      default: res = {cur_hi, cur_lo};
    endcase
    return res;
  endfunction

  task automatic model_step(input logic sig, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    logic [63:0] r;
    if (m_cnt == 0) begin
      if (sig) begin
        if (op >= 3'd1 && op <= 3'd4) begin
          r = ref_result(op, a, b, m_hi, m_lo);
          {m_ph, m_pl} = r;
          m_cnt = (op <= 3'd2) ? 5 : 10;
          exp_q.push_back(r);
        end else if (op == 3'd5) begin
          m_hi = a;
        end else if (op == 3'd6) begin
          m_lo = a;
        end
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0;
    exp_q.delete();
  endtask

  // driver: called at a negedge, drives for one clock, checks at the next negedge
  task automatic cycle(input logic sig, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    md_signal = sig; md_control = op; e_a = a; e_b = b;
    @(posedge clk);
    model_step(sig, op, a, b);
    @(negedge clk);
    check32("busy", {28'd0, busy}, m_cnt[31:0]);
    check32("hi", res_hi, m_hi);
    check32("lo", res_lo, m_lo);
    check32("state", {31'd0, st == ST_RUN}, {31'd0, m_cnt != 0});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    cycle(1'b1, op, a, b);
    while (m_cnt != 0 && guard < 20) begin
      cycle(1'b0, 3'd0, 32'd0, 32'd0);
      guard++;
    end
    if (m_cnt != 0) check32("run_timeout", 32'(m_cnt), 32'd0);
  endtask

  // monitor: a busy 1->0 transition is the DUT presenting a committed result
  int prev_busy = 0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      prev_busy = 0;
    end else begin
      if (prev_busy == 1 && busy == 4'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL commit_unexpected actual=%h_%h expected=none", res_hi, res_lo);
        end else begin
          e = exp_q.pop_front();
          check32("commit_hi", res_hi, e[63:32]);
          check32("commit_lo", res_lo, e[31:0]);
        end
      end
      prev_busy = int'(busy);
    end
  end

  initial begin
    logic        sig;
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n = 1'b0; md_signal = 0; md_control = 0; e_a = 0; e_b = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check32("reset_busy", {28'd0, busy}, 32'd0);
    check32("reset_hi", res_hi, 32'd0);
    check32("reset_lo", res_lo, 32'd0);
    rst_n = 1'b1;

    // reset in the middle of a multiply
    cycle(1'b1, MD_MULT, 32'd3, 32'd4);
    idle(3);
    check32("t1_busy_before_reset", {28'd0, busy}, 32'd2);
    rst_n = 1'b0;
    #1;
    check32("t1_busy_async", {28'd0, busy}, 32'd0);
    check32("t1_hi_async", res_hi, 32'd0);
    check32("t1_lo_async", res_lo, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check32("t1_no_commit_lo", res_lo, 32'd0);

    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    check32("t2_mult_hi", res_hi, 32'hFFFF_FFFF);
    check32("t2_mult_lo", res_lo, 32'hFFFF_FFFE);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    check32("t2_multu_hi", res_hi, 32'h0000_0001);
    check32("t2_multu_lo", res_lo, 32'hFFFF_FFFE);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check32("t3_div_hi", res_hi, 32'hFFFF_FFFF);
    check32("t3_div_lo", res_lo, 32'hFFFF_FFFD);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check32("t3_ovf_hi", res_hi, 32'd0);
    check32("t3_ovf_lo", res_lo, 32'h8000_0000);

    cycle(1'b1, MD_MTHI, 32'h1234, 32'd0);
    cycle(1'b1, MD_MTLO, 32'h5678, 32'd0);
    run_op(MD_DIVU, 32'd9, 32'd0);
    check32("t4_div0_hi", res_hi, 32'h1234);
    check32("t4_div0_lo", res_lo, 32'h5678);

    cycle(1'b1, MD_MULT, 32'd2, 32'd3);
    idle(2);
    check32("t5_busy3", {28'd0, busy}, 32'd3);
    cycle(1'b1, MD_MTLO, 32'hAA, 32'd0);
    idle(3);
    check32("t5_hi", res_hi, 32'd0);
    check32("t5_lo", res_lo, 32'd6);

    cycle(1'b1, MD_MTHI, 32'hDEAD, 32'd0);
    check32("t6_mthi", res_hi, 32'hDEAD);
    check32("t6_busy", {28'd0, busy}, 32'd0);
    run_op(MD_DIVU, 32'd100, 32'd7);
    check32("t6_divu_hi", res_hi, 32'd2);
    check32("t6_divu_lo", res_lo, 32'd14);

    // start on the committing edge is dropped
    cycle(1'b1, MD_MULTU, 32'd5, 32'd5);
    idle(4);
    cycle(1'b1, MD_MTHI, 32'hBEEF, 32'd0);
    check32("b2b_hi", res_hi, 32'd0);
    check32("b2b_lo", res_lo, 32'd25);

    // random traffic, including starts during RUN and corner operands
    repeat (400) begin
      sig = ($urandom_range(0, 2) == 0);
      op  = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'($urandom_range(0, 200)) - 32'd100; b = 32'($urandom_range(0, 20)) - 32'd10; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      cycle(sig, op, a, b);
    end
    idle(12);
    check32("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
